uart_rx_fifo: RTL and testbench
===============================

Name: uart_rx_fifo

Overview:
Parametrised successor to the team's fixed 8N1 UART receiver. It oversamples a serial line at CLKS_PER_BIT clocks per bit and supports configurable data width, parity and stop-bit count. It rejects false start bits and flags parity and framing errors per word. Received words are buffered in an on-chip FIFO with a valid/ready output handshake, so the processor side can stall without losing frames.

Parameters:
CLKS_PER_BIT, 2604, clock cycles per serial bit (≥8); 2604 = 38400 baud at 100 MHz
DATA_BITS, 8, data bits per frame, 5..9, LSB first
PARITY, 0, 0 none / 1 odd / 2 even
STOP_BITS, 1, 1 or 2
FIFO_DEPTH, 4, receive FIFO entries; power of 2, ≥2

Ports:
CLK  in  1  system clock; all logic on rising edge
RESET_N  in  1  synchronous, active-low reset
RX  in  1  asynchronous serial input, idle high
RX_DATA  out  DATA_BITS  data of FIFO head word
RX_PERR  out  1  parity error flag of head word (0 when PARITY=0)
RX_FERR  out  1  framing error flag of head word
RX_VALID  out  1  FIFO not empty
RX_READY  in  1  consumer accepts head word when RX_VALID & RX_READY
RX_DONE  out  1  one-cycle pulse when a frame completes, whether or not it is stored
OVERRUN  out  1  one-cycle pulse when a completed frame is dropped because the FIFO is full
FIFO_COUNT  out  clog2(FIFO_DEPTH)+1  stored word count

Behaviour:
- Reset (RESET_N=0 at a CLK edge): state IDLE, counters 0, synchronizer FFs set to 1, FIFO empty. Outputs after reset: RX_VALID=0, RX_DATA=0, RX_PERR=0, RX_FERR=0, RX_DONE=0, OVERRUN=0, FIFO_COUNT=0. Reset mid-frame aborts the frame silently.
- RX passes through a 2-FF synchronizer; rxs denotes the synchronizer output. All line decisions use rxs.
- Bit counter cnt runs 0..CLKS_PER_BIT-1. MID = (CLKS_PER_BIT-1)/2 (integer division).
- FSM states: IDLE, START, DATA, PAR, STOP, WAIT_HIGH.
  - IDLE: rxs=0 → START with cnt=0.
  - START: at cnt=MID, sample rxs. rxs=1 means a glitch → IDLE. rxs=0 → DATA with cnt=0, bit index=0.
  - DATA: sample rxs into shift[idx] at cnt=CLKS_PER_BIT-1, giving mid-bit sampling. After DATA_BITS samples → PAR if PARITY≠0, else STOP.
  - PAR: sample at cnt=CLKS_PER_BIT-1.
    - Odd parity: perr = ~(^data ^ p).
    - Even parity: perr = ^data ^ p.
  - STOP: sample each stop bit at cnt=CLKS_PER_BIT-1. ferr = 1 if any stop sample is 0. After the last stop sample the frame completes, then:
    - ferr=0 → IDLE.
    - ferr=1 → WAIT_HIGH.
  - WAIT_HIGH: stay until rxs=1, then IDLE. A break or stuck-low line therefore produces exactly one frame.
- Frame completion (the cycle after the last stop sample):
  - RX_DONE pulses for one cycle.
  - If FIFO is not full, or a pop occurs in the same cycle, {ferr, perr, data} is written. RX_VALID/FIFO_COUNT update on that edge.
  - If FIFO is full with no same-cycle pop: the word is dropped, FIFO contents are unchanged, and OVERRUN pulses for one cycle.
- Pop happens on a CLK edge with RX_VALID & RX_READY. The head advances next cycle.
- Simultaneous push and pop: FIFO_COUNT is unchanged, both take effect, and ordering is preserved. With an empty FIFO, a push and RX_READY=1 in the same cycle is not a pop.
- RX_DATA/RX_PERR/RX_FERR hold the head word while RX_VALID=1. They are don't-care when RX_VALID=0, but must not be X after reset.
- Read and write pointers wrap modulo FIFO_DEPTH. Full = count==FIFO_DEPTH.
- Back-to-back frames: because the FSM returns to IDLE at mid-stop, a start edge is accepted immediately after the stop bit with no idle gap.

Test Plan:
1. Defaults, 10 ns CLK. Send 0x2D then, after 100 ns idle, 0x30 → two RX_DONE pulses; FIFO_COUNT=2; popping yields 0x2D, then 0x30, both with PERR=FERR=0.
2. CLKS_PER_BIT=16, PARITY=2 (even). Send 0xA5 with correct parity 0, then 0xA5 with parity bit 1 → first word PERR=0, second word PERR=1, data 0xA5 both times.
3. CLKS_PER_BIT=16. Drive RX low for 5 clocks then high → no RX_DONE, FSM back in IDLE. Then send 0x5A → 0x5A received.
4. CLKS_PER_BIT=16, FIFO_DEPTH=4, RX_READY=0. Send 0x01..0x05 back-to-back → FIFO_COUNT=4, one OVERRUN pulse on frame 5; pops return 0x01..0x04.
5. Stop bit forced 0 on 0x33, with the line held low for 3 bit times → exactly one word, 0x33 with FERR=1. Next frame 0x44 is received cleanly after the line returns high.
6. Assert RESET_N=0 mid-frame with 2 words stored → next cycle RX_VALID=0 and FIFO_COUNT=0. A following frame 0x7E is received correctly.

Source files
------------

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: oversampling UART receiver with a receive FIFO.
//
// The receiver has a configurable data width, an optional odd or even parity bit, and one
// or two stop bits. It rejects false start bits and flags parity and framing errors for
// each word. Each completed frame is pushed into a FIFO as {ferr, perr, data}. The
// consumer pops the head word through a valid/ready handshake.
//
// Ports:
//   CLK         system clock, rising edge
//   RESET_N     synchronous active-low reset
//   RX          asynchronous serial input, idle high
//   RX_DATA     data of the FIFO head word
//   RX_PERR     parity error flag of the head word (0 when PARITY=0)
//   RX_FERR     framing error flag of the head word
//   RX_VALID    FIFO not empty
//   RX_READY    consumer accepts the head word when RX_VALID & RX_READY
//   RX_DONE     one-cycle pulse per completed frame, stored or not
//   OVERRUN     one-cycle pulse when a completed frame is dropped on a full FIFO
//   FIFO_COUNT  number of stored words
module uart_rx_fifo #(
    parameter int unsigned CLKS_PER_BIT = 2604,
    parameter int unsigned DATA_BITS    = 8,
    parameter int unsigned PARITY       = 0,
    parameter int unsigned STOP_BITS    = 1,
    parameter int unsigned FIFO_DEPTH   = 4
) (
    input  logic                          CLK,
    input  logic                          RESET_N,
    input  logic                          RX,
    output logic [DATA_BITS-1:0]          RX_DATA,
    output logic                          RX_PERR,
    output logic                          RX_FERR,
    output logic                          RX_VALID,
    input  logic                          RX_READY,
    output logic                          RX_DONE,
    output logic                          OVERRUN,
    output logic [$clog2(FIFO_DEPTH):0]   FIFO_COUNT
);

    localparam int unsigned CNT_W  = $clog2(CLKS_PER_BIT);
    localparam int unsigned IDX_W  = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
    localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
    localparam int unsigned FCNT_W = PTR_W + 1;
    localparam int unsigned WORD_W = DATA_BITS + 2;

    localparam logic [CNT_W-1:0]  CNT_LAST   = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0]  CNT_MID    = CNT_W'((CLKS_PER_BIT - 1) / 2);
    localparam logic [IDX_W-1:0]  IDX_LAST   = IDX_W'(DATA_BITS - 1);
    localparam logic              STOP_LAST  = (STOP_BITS == 2);
    localparam logic [FCNT_W-1:0] FULL_COUNT = FCNT_W'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StPar,
        StStop,
        StWaitHigh
    } state_e;

    // Receiver state
    logic [1:0]           sync_q;
    logic                 rxs;
    state_e               state_q;
    logic [CNT_W-1:0]     cnt_q;
    logic [IDX_W-1:0]     idx_q;
    logic                 stop_idx_q;
    logic [DATA_BITS-1:0] shift_q;
    logic                 perr_q;
    logic                 ferr_q;
    logic                 done_q;

    // FIFO state
    logic [WORD_W-1:0]    mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]     wr_ptr_q;
    logic [PTR_W-1:0]     rd_ptr_q;
    logic [FCNT_W-1:0]    count_q;
    logic                 full;
    logic                 push;
    logic                 pop;
    logic                 stop_bad;

    assign rxs = sync_q[1];

    // Framing error status including the stop sample taken on this cycle
    assign stop_bad = ferr_q | ~rxs;

    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            sync_q     <= 2'b11;
            state_q    <= StIdle;
            cnt_q      <= '0;
            idx_q      <= '0;
            stop_idx_q <= 1'b0;
            shift_q    <= '0;
            perr_q     <= 1'b0;
            ferr_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            sync_q <= {sync_q[0], RX};
            done_q <= 1'b0;
            case (state_q)
                StIdle: begin
                    cnt_q <= '0;
                    if (!rxs) begin
                        state_q <= StStart;
                        perr_q  <= 1'b0;
                        ferr_q  <= 1'b0;
                    end
                end
                StStart: begin
                    if (cnt_q == CNT_MID) begin
                        // Line high again at mid-start means the low pulse was a glitch
                        cnt_q   <= '0;
                        idx_q   <= '0;
                        state_q <= rxs ? StIdle : StData;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                StData: begin
                    if (cnt_q == CNT_LAST) begin
                        cnt_q          <= '0;
                        shift_q[idx_q] <= rxs;
                        idx_q          <= idx_q + 1'b1;
                        if (idx_q == IDX_LAST) begin
                            stop_idx_q <= 1'b0;
                            state_q    <= (PARITY != 0) ? StPar : StStop;
                        end
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                StPar: begin
                    if (cnt_q == CNT_LAST) begin
                        cnt_q   <= '0;
                        perr_q  <= (PARITY == 1) ? ~(^shift_q ^ rxs) : (^shift_q ^ rxs);
                        state_q <= StStop;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                StStop: begin
                    if (cnt_q == CNT_LAST) begin
                        cnt_q  <= '0;
                        ferr_q <= stop_bad;
                        if (stop_idx_q == STOP_LAST) begin
                            // Leaving at mid-stop lets a back-to-back start edge be seen
                            done_q  <= 1'b1;
                            state_q <= stop_bad ? StWaitHigh : StIdle;
                        end else begin
                            stop_idx_q <= stop_idx_q + 1'b1;
                        end
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                StWaitHigh: begin
                    // A break or stuck-low line yields one frame, not a stream of them
                    if (rxs) begin
                        state_q <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign full = (count_q == FULL_COUNT);
    assign pop  = RX_VALID & RX_READY;
    assign push = done_q & (~full | pop);

    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            if (push) begin
                mem_q[wr_ptr_q] <= {ferr_q, perr_q, shift_q};
                wr_ptr_q        <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    assign {RX_FERR, RX_PERR, RX_DATA} = mem_q[rd_ptr_q];
    assign RX_VALID   = (count_q != '0);
    assign RX_DONE    = done_q;
    assign OVERRUN    = done_q & full & ~pop;
    assign FIFO_COUNT = count_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo: instance a (no parity) and instance b (even parity),
// both at 16 clocks per bit.
module tb_uart_rx_fifo;

    localparam int unsigned CPB = 16;

    logic       clk;
    logic       reset_n;
    logic       rx_a, rx_b;
    logic       ready_a, ready_b;
    logic [7:0] data_a, data_b;
    logic       perr_a, perr_b, ferr_a, ferr_b;
    logic       valid_a, valid_b, done_a, done_b, ovr_a, ovr_b;
    logic [2:0] count_a, count_b;

    int checks = 0;
    int errors = 0;
    int n_done_a = 0;
    int n_ovr_a = 0;
    int n_done_b = 0;

    uart_rx_fifo #(
        .CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(4)
    ) dut_a (
        .CLK(clk), .RESET_N(reset_n), .RX(rx_a), .RX_DATA(data_a), .RX_PERR(perr_a),
        .RX_FERR(ferr_a), .RX_VALID(valid_a), .RX_READY(ready_a), .RX_DONE(done_a),
        .OVERRUN(ovr_a), .FIFO_COUNT(count_a)
    );

    uart_rx_fifo #(
        .CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1), .FIFO_DEPTH(4)
    ) dut_b (
        .CLK(clk), .RESET_N(reset_n), .RX(rx_b), .RX_DATA(data_b), .RX_PERR(perr_b),
        .RX_FERR(ferr_b), .RX_VALID(valid_b), .RX_READY(ready_b), .RX_DONE(done_b),
        .OVERRUN(ovr_b), .FIFO_COUNT(count_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Pulse counters: each counts cycles the output is high
    always @(posedge clk) begin
        if (done_a) n_done_a <= n_done_a + 1;
        if (ovr_a)  n_ovr_a  <= n_ovr_a + 1;
        if (done_b) n_done_b <= n_done_b + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input bit sel, input logic v);
        if (sel) rx_b = v;
        else     rx_a = v;
    endtask

    // One frame LSB first; the line is left at the stop value on return
    task automatic send(input bit sel, input logic [7:0] d, input bit use_par,
                        input logic p, input logic stop);
        drive(sel, 1'b0);
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            drive(sel, d[i]);
            repeat (CPB) @(negedge clk);
        end
        if (use_par) begin
            drive(sel, p);
            repeat (CPB) @(negedge clk);
        end
        drive(sel, stop);
        repeat (CPB) @(negedge clk);
    endtask

    task automatic pop_check(input bit sel, input string tag, input logic [7:0] d,
                             input logic pe, input logic fe);
        if (sel) begin
            check({tag, " valid"}, {31'd0, valid_b}, 32'd1);
            check({tag, " data"},  {24'd0, data_b},  {24'd0, d});
            check({tag, " perr"},  {31'd0, perr_b},  {31'd0, pe});
            check({tag, " ferr"},  {31'd0, ferr_b},  {31'd0, fe});
            ready_b = 1'b1;
            @(negedge clk);
            ready_b = 1'b0;
        end else begin
            check({tag, " valid"}, {31'd0, valid_a}, 32'd1);
            check({tag, " data"},  {24'd0, data_a},  {24'd0, d});
            check({tag, " perr"},  {31'd0, perr_a},  {31'd0, pe});
            check({tag, " ferr"},  {31'd0, ferr_a},  {31'd0, fe});
            ready_a = 1'b1;
            @(negedge clk);
            ready_a = 1'b0;
        end
    endtask

    initial begin
        int d0;
        int o0;
        reset_n = 1'b0;
        rx_a    = 1'b1;
        rx_b    = 1'b1;
        ready_a = 1'b0;
        ready_b = 1'b0;
        repeat (3) @(negedge clk);

        // Reset state
        check("rst valid", {31'd0, valid_a}, 32'd0);
        check("rst data",  {24'd0, data_a},  32'd0);
        check("rst perr",  {31'd0, perr_a},  32'd0);
        check("rst ferr",  {31'd0, ferr_a},  32'd0);
        check("rst done",  {31'd0, done_a},  32'd0);
        check("rst ovr",   {31'd0, ovr_a},   32'd0);
        check("rst count", {29'd0, count_a}, 32'd0);
        reset_n = 1'b1;
        repeat (5) @(negedge clk);

        // Two frames with a 100 ns gap
        d0 = n_done_a;
        send(1'b0, 8'h2D, 1'b0, 1'b0, 1'b1);
        repeat (10) @(negedge clk);
        send(1'b0, 8'h30, 1'b0, 1'b0, 1'b1);
        repeat (4) @(negedge clk);
        check("t1 dones", n_done_a - d0, 32'd2);
        check("t1 count", {29'd0, count_a}, 32'd2);
        pop_check(1'b0, "t1 w0", 8'h2D, 1'b0, 1'b0);
        pop_check(1'b0, "t1 w1", 8'h30, 1'b0, 1'b0);
        check("t1 empty", {29'd0, count_a}, 32'd0);

        // Even parity: 0xA5 has four ones, so parity bit 0 is correct
        send(1'b1, 8'hA5, 1'b1, 1'b0, 1'b1);
        send(1'b1, 8'hA5, 1'b1, 1'b1, 1'b1);
        repeat (4) @(negedge clk);
        check("t2 dones", n_done_b, 32'd2);
        check("t2 count", {29'd0, count_b}, 32'd2);
        pop_check(1'b1, "t2 good", 8'hA5, 1'b0, 1'b0);
        pop_check(1'b1, "t2 bad",  8'hA5, 1'b1, 1'b0);

        // Start-bit glitch is rejected
        d0 = n_done_a;
        rx_a = 1'b0;
        repeat (5) @(negedge clk);
        rx_a = 1'b1;
        repeat (40) @(negedge clk);
        check("t3 glitch dones", n_done_a - d0, 32'd0);
        check("t3 glitch valid", {31'd0, valid_a}, 32'd0);
        send(1'b0, 8'h5A, 1'b0, 1'b0, 1'b1);
        repeat (4) @(negedge clk);
        check("t3 dones", n_done_a - d0, 32'd1);
        pop_check(1'b0, "t3 w0", 8'h5A, 1'b0, 1'b0);

        // Overrun: five back-to-back frames into a four-entry FIFO, no pops
        d0 = n_done_a;
        o0 = n_ovr_a;
        for (int i = 1; i <= 5; i++) begin
            send(1'b0, 8'(i), 1'b0, 1'b0, 1'b1);
        end
        repeat (4) @(negedge clk);
        check("t4 dones", n_done_a - d0, 32'd5);
        check("t4 overruns", n_ovr_a - o0, 32'd1);
        check("t4 count", {29'd0, count_a}, 32'd4);
        for (int i = 1; i <= 4; i++) begin
            pop_check(1'b0, $sformatf("t4 w%0d", i), 8'(i), 1'b0, 1'b0);
        end
        check("t4 empty", {29'd0, count_a}, 32'd0);

        // Framing error with the line held low for three bit times
        d0 = n_done_a;
        send(1'b0, 8'h33, 1'b0, 1'b0, 1'b0);
        repeat (2 * CPB) @(negedge clk);
        check("t5 break dones", n_done_a - d0, 32'd1);
        check("t5 break count", {29'd0, count_a}, 32'd1);
        rx_a = 1'b1;
        repeat (2 * CPB) @(negedge clk);
        send(1'b0, 8'h44, 1'b0, 1'b0, 1'b1);
        repeat (4) @(negedge clk);
        check("t5 dones", n_done_a - d0, 32'd2);
        pop_check(1'b0, "t5 w0", 8'h33, 1'b0, 1'b1);
        pop_check(1'b0, "t5 w1", 8'h44, 1'b0, 1'b0);

        // Reset mid-frame with two words stored
        send(1'b0, 8'h11, 1'b0, 1'b0, 1'b1);
        send(1'b0, 8'h22, 1'b0, 1'b0, 1'b1);
        repeat (4) @(negedge clk);
        check("t6 pre count", {29'd0, count_a}, 32'd2);
        rx_a = 1'b0;
        repeat (CPB) @(negedge clk);
        rx_a = 1'b1;
        repeat (CPB) @(negedge clk);
        rx_a = 1'b0;
        repeat (CPB / 2) @(negedge clk);
        d0 = n_done_a;
        reset_n = 1'b0;
        @(negedge clk);
        check("t6 rst valid", {31'd0, valid_a}, 32'd0);
        check("t6 rst count", {29'd0, count_a}, 32'd0);
        reset_n = 1'b1;
        rx_a = 1'b1;
        repeat (2 * CPB) @(negedge clk);
        check("t6 aborted dones", n_done_a - d0, 32'd0);
        send(1'b0, 8'h7E, 1'b0, 1'b0, 1'b1);
        repeat (4) @(negedge clk);
        check("t6 dones", n_done_a - d0, 32'd1);
        check("t6 count", {29'd0, count_a}, 32'd1);
        pop_check(1'b0, "t6 w0", 8'h7E, 1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
